// File: rtl/pipelined_adder_pkg.sv
// Shared types and helpers for the segmented, handshaked add/sub pipeline.
package pipelined_adder_pkg;

  // Widest datapath is 64-bit operands plus the extension bit, with one
  // spare bit so the bits above the live width never form an empty slice.
  localparam int MAX_W = 66;

  // One pipeline stage's register contents. Bits of sum/pa/pb at or above
  // the live width are always zero.
  typedef struct packed {
    logic             valid;
    logic             sub;
    logic             carry;
    logic [MAX_W-1:0] sum;
    logic [MAX_W-1:0] pa;
    logic [MAX_W-1:0] pb;
  } stage_rec_t;

  // Bits per carry segment: ceil(w / n).
  function automatic int seg_width(input int w, input int n);
    return (w + n - 1) / n;
  endfunction

  // Lowest bit of segment k. The final segments may come out narrower than
  // the rest, or even empty; the value is clamped to w.
  function automatic int seg_lo(input int k, input int w, input int n);
    int lo;
    lo = k * seg_width(w, n);
    return (lo > w) ? w : lo;
  endfunction

endpackage

// File: rtl/addsub_seg_stage.sv
// A single carry segment: ripple-adds bits [LO, HI) using the carry left
// by the previous stage. Operand bits that are not yet summed travel along
// in the same register. The stage owns one valid bit and loads when it is
// empty or when the stage downstream takes its contents.
module addsub_seg_stage
  import pipelined_adder_pkg::*;
#(
  parameter int LO = 0,
  parameter int HI = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  stage_rec_t rec_i,
  input  logic       down_ready_i,
  output logic       load_o,
  output stage_rec_t rec_o
);

  stage_rec_t rec_q;
  stage_rec_t rec_d;

  // Add this stage's segment. An empty segment simply passes the carry on.
  always_comb begin : seg_add
    logic c;
    rec_d = rec_i;
    c     = rec_i.carry;
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= LO && i < HI) begin
        rec_d.sum[i] = rec_i.pa[i] ^ rec_i.pb[i] ^ c;
        c = (rec_i.pa[i] & rec_i.pb[i]) | (c & (rec_i.pa[i] ^ rec_i.pb[i]));
      end
    end
    rec_d.carry = c;
  end

  assign load_o = !rec_q.valid || down_ready_i;

  // Stage register. A bubble may overwrite the data, because the data is
  // only meaningful while valid is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q <= '0;
    end else if (load_o) begin
      rec_q <= rec_d;
    end
  end

  assign rec_o = rec_q;

endmodule

// File: rtl/pipelined_addsub_hs.sv
// Valid/ready add/subtract unit. Both operands are extended by one bit and
// the sum is computed across NUM_REG registered carry segments, giving a
// latency of NUM_REG cycles and a throughput of one result per cycle.
module pipelined_addsub_hs
  import pipelined_adder_pkg::*;
#(
  parameter int INP_DW  = 8,
  parameter int NUM_REG = 4,
  parameter int SIGNED  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INP_DW-1:0] inp1,
  input  logic [INP_DW-1:0] inp2,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INP_DW:0]   outp,
  output logic              out_ovf
);

  localparam int W = INP_DW + 1;

  stage_rec_t       head;
  stage_rec_t       chain [NUM_REG+1];
  logic [NUM_REG:0] load;
  logic [W-1:0]     a_ext;
  logic [W-1:0]     b_ext;
  logic             unused_tail;

  assign a_ext = {(SIGNED != 0) & inp1[INP_DW-1], inp1};
  assign b_ext = {(SIGNED != 0) & inp2[INP_DW-1], inp2};

  // Entry record: subtraction becomes an add of the inverted operand with
  // carry-in 1, so no stage needs to know which operation it is doing.
  always_comb begin
    head            = '0;
    head.valid      = in_valid;
    head.sub        = in_sub;
    head.carry      = in_sub;
    head.pa[W-1:0]  = a_ext;
    head.pb[W-1:0]  = b_ext ^ {W{in_sub}};
  end

  assign chain[0]      = head;
  assign load[NUM_REG] = out_ready;
  assign in_ready      = load[0];

  for (genvar k = 0; k < NUM_REG; k++) begin : g_stage
    addsub_seg_stage #(
      .LO(seg_lo(k, W, NUM_REG)),
      .HI(seg_lo(k + 1, W, NUM_REG))
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .rec_i       (chain[k]),
      .down_ready_i(load[k+1]),
      .load_o      (load[k]),
      .rec_o       (chain[k+1])
    );
  end

  assign out_valid = chain[NUM_REG].valid;
  assign outp      = chain[NUM_REG].sum[W-1:0];

  if (SIGNED != 0) begin : g_ovf_s
    assign out_ovf = outp[INP_DW] ^ outp[INP_DW-1];
  end else begin : g_ovf_u
    assign out_ovf = outp[INP_DW];
  end

  // Fields of the last stage that leave the block through no port.
  assign unused_tail = ^{chain[NUM_REG].sum[MAX_W-1:W], chain[NUM_REG].pa,
                         chain[NUM_REG].pb, chain[NUM_REG].sub,
                         chain[NUM_REG].carry};

endmodule

// File: tb/tb_pipelined_addsub_hs.sv
// Bench for pipelined_addsub_hs: directed vectors, a stall stream, reset
// while busy, and a NUM_REG sweep on random traffic.
module tb_pipelined_addsub_hs;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic       in_valid, in_sub, out_ready;
  logic [7:0] inp1, inp2;
  logic       a_in_ready, a_out_valid, a_out_ovf;
  logic [8:0] a_outp;
  logic       s_in_ready, s_out_valid, s_out_ovf;
  logic [8:0] s_outp;

  logic       w_valid, w_sub, w_rdy;
  logic [7:0] w_a, w_b;
  logic [2:0] sw_in_ready, sw_out_valid, sw_out_ovf;
  logic [8:0] sw_outp [3];
  logic       sweep_on, sweep_end;

  pipelined_addsub_hs #(.INP_DW(8), .NUM_REG(4), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .inp1(inp1), .inp2(inp2), .in_sub(in_sub), .out_valid(a_out_valid),
    .out_ready(out_ready), .outp(a_outp), .out_ovf(a_out_ovf));

  pipelined_addsub_hs #(.INP_DW(8), .NUM_REG(4), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .inp1(inp1), .inp2(inp2), .in_sub(in_sub), .out_valid(s_out_valid),
    .out_ready(out_ready), .outp(s_outp), .out_ovf(s_out_ovf));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Unsigned 9-bit reference; wraps mod 512.
  function automatic logic [8:0] ref_u(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [8:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return sub ? (ea - eb) : (ea + eb);
  endfunction

  typedef struct {
    logic [8:0] v;
    int         t;
  } sb_t;

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int NR = (g == 0) ? 1 : ((g == 1) ? 5 : 9);
    sb_t  q [$];
    logic done = 1'b0;

    pipelined_addsub_hs #(.INP_DW(8), .NUM_REG(NR), .SIGNED(0)) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(sw_in_ready[g]),
      .inp1(w_a), .inp2(w_b), .in_sub(w_sub), .out_valid(sw_out_valid[g]),
      .out_ready(w_rdy), .outp(sw_outp[g]), .out_ovf(sw_out_ovf[g]));

    always @(negedge clk) begin
      if (sweep_on) begin
        if (w_valid) begin
          chk($sformatf("sweep%0d_in_ready", NR), sw_in_ready[g], 1);
          if (sw_in_ready[g]) q.push_back(sb_t'{ref_u(w_a, w_b, w_sub), cyc});
        end
        if (sw_out_valid[g]) begin
          if (q.size() == 0) begin
            chk($sformatf("sweep%0d_spurious_out", NR), sw_out_valid[g], 0);
          end else begin
            sb_t e;
            e = q.pop_front();
            chk($sformatf("sweep%0d_outp", NR), sw_outp[g], e.v);
            chk($sformatf("sweep%0d_ovf", NR), sw_out_ovf[g], e.v[8]);
            chk($sformatf("sweep%0d_latency", NR), cyc - e.t, NR);
          end
        end
        if (sweep_end && !done) begin
          chk($sformatf("sweep%0d_leftover", NR), q.size(), 0);
          done = 1'b1;
        end
      end
    end
  end

  typedef struct {
    logic       sgn;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
    logic       ovf;
    string      name;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input logic sgn, input logic sub, input logic [7:0] a,
                         input logic [7:0] b, input logic [8:0] exp, input logic ovf,
                         input string name);
    vec_t v;
    v.sgn = sgn; v.sub = sub; v.a = a; v.b = b; v.exp = exp; v.ovf = ovf; v.name = name;
    vecs.push_back(v);
  endtask

  // Sends one pair into an empty pipe and checks latency and result.
  task automatic run_vec(input vec_t v);
    int   lat;
    logic got;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    inp1      = v.a;
    inp2      = v.b;
    in_sub    = v.sub;
    out_ready = 1'b1;
    @(negedge clk);
    chk({v.name, "_in_ready"}, v.sgn ? s_in_ready : a_in_ready, 1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      inp1     = 8'($urandom);
      inp2     = 8'($urandom);
      in_sub   = ~v.sub;
      lat++;
      got = v.sgn ? s_out_valid : a_out_valid;
    end
    chk({v.name, "_seen"}, got, 1);
    chk({v.name, "_latency"}, lat, 4);
    chk({v.name, "_outp"}, v.sgn ? s_outp : a_outp, v.exp);
    chk({v.name, "_ovf"}, v.sgn ? s_out_ovf : a_out_ovf, v.ovf);
  endtask

  function automatic logic [7:0] pair_a(input int i);
    return 8'(i * 37 + 11);
  endfunction
  function automatic logic [7:0] pair_b(input int i);
    return 8'(i * 23 + 200);
  endfunction

  initial begin
    int         idx, popped, hits;
    logic [8:0] q_exp [$];
    logic [8:0] held, e;
    logic       held_v;

    rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    inp1 = '0; inp2 = '0;
    w_valid = 1'b0; w_sub = 1'b0; w_a = '0; w_b = '0; w_rdy = 1'b1;
    sweep_on = 1'b0; sweep_end = 1'b0;

    add_vec(0, 0, 8'd200, 8'd55,  9'h0FF, 0, "u_200p55");
    add_vec(0, 0, 8'd200, 8'd100, 9'h12C, 1, "u_200p100");
    add_vec(0, 1, 8'd5,   8'd10,  9'h1FB, 1, "u_5m10");
    add_vec(0, 1, 8'd10,  8'd5,   9'h005, 0, "u_10m5");
    add_vec(0, 0, 8'hFF,  8'hFF,  9'h1FE, 1, "u_255p255");
    add_vec(0, 1, 8'h00,  8'h00,  9'h000, 0, "u_0m0");
    add_vec(0, 1, 8'h00,  8'hFF,  9'h101, 1, "u_0m255");
    add_vec(0, 1, 8'hFF,  8'h00,  9'h0FF, 0, "u_255m0");
    add_vec(1, 0, 8'h7F,  8'h01,  9'h080, 1, "s_127p1");
    add_vec(1, 1, 8'h80,  8'h01,  9'h17F, 1, "s_m128m1");
    add_vec(1, 0, 8'hFD,  8'hFC,  9'h1F9, 0, "s_m3pm4");
    add_vec(1, 1, 8'h7F,  8'h80,  9'h0FF, 1, "s_127mm128");
    add_vec(1, 1, 8'hFF,  8'hFF,  9'h000, 0, "s_m1mm1");
    add_vec(1, 0, 8'h80,  8'h80,  9'h100, 1, "s_m128pm128");

    #12;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_outp", a_outp, 0);
    chk("rst_ovf", a_out_ovf, 0);
    chk("rst_s_out_valid", s_out_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", a_in_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Stream of 16 pairs with the consumer stalled for cycles 3..8.
    idx = 0; popped = 0; held_v = 1'b0; held = '0;
    for (int c = 0; c < 100 && popped < 16; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 3 && c <= 8);
      in_valid  = (idx < 16);
      if (idx < 16) begin
        inp1   = pair_a(idx);
        inp2   = pair_b(idx);
        in_sub = idx[0];
      end
      @(negedge clk);
      if (c == 5) begin
        chk("stall_accepted", idx, 4);
        chk("stall_in_ready", a_in_ready, 0);
      end
      if (in_valid && a_in_ready) begin
        q_exp.push_back(ref_u(inp1, inp2, in_sub));
        idx++;
      end
      if (a_out_valid) begin
        if (out_ready) begin
          popped++;
          held_v = 1'b0;
          if (q_exp.size() == 0) begin
            chk("stream_spurious_out", a_out_valid, 0);
          end else begin
            e = q_exp.pop_front();
            chk($sformatf("stream_res%0d", popped), {a_out_ovf, a_outp}, {e[8], e});
          end
        end else begin
          if (held_v) chk("stall_stable", {a_out_ovf, a_outp}, {held[8], held});
          held   = a_outp;
          held_v = 1'b1;
        end
      end
    end
    chk("stream_count", popped, 16);
    chk("stream_accepted", idx, 16);

    // Reset with three pairs in flight and the head result waiting.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; inp1 = 8'(50 + i); inp2 = 8'(7 * i); in_sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("inflight_out_valid", a_out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", a_out_valid, 0);
    chk("async_rst_outp", a_outp, 0);
    chk("async_rst_ovf", a_out_ovf, 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", a_in_ready, 1);
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_out_valid) hits++;
    end
    chk("no_stale_after_rst", hits, 0);
    begin
      vec_t v;
      v.sgn = 0; v.sub = 0; v.a = 8'd1; v.b = 8'd1; v.exp = 9'd2; v.ovf = 0; v.name = "post_rst_1p1";
      run_vec(v);
    end

    // NUM_REG sweep on random traffic with the consumer always ready.
    @(posedge clk); #1;
    sweep_on = 1'b1;
    for (int i = 0; i < 200; i++) begin
      w_valid = ($urandom % 4) != 0;
      w_a     = 8'($urandom);
      w_b     = 8'($urandom);
      w_sub   = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    sweep_end = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sweep_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub_hs.md
PIPELINED_ADDSUB_HS -- requirements
Module: pipelined_addsub_hs

Interface
REQ-001 SHALL have parameter INP_DW, default 8: operand width, legal range 2..64.
REQ-002 SHALL have parameter NUM_REG, default 4: pipeline stages (carry segments), legal range 1..INP_DW+1.
REQ-003 SHALL have parameter SIGNED, default 0: 0 treats operands as unsigned, 1 as two's complement.
REQ-004 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: upstream offers an operand pair.
REQ-007 SHALL have port in_ready, output, 1: block accepts the pair this cycle.
REQ-008 SHALL have ports inp1 and inp2, input, INP_DW each: operands.
REQ-009 SHALL have port in_sub, input, 1: 1 = inp1-inp2, 0 = inp1+inp2.
REQ-010 SHALL have port out_valid, output, 1: outp/out_ovf hold a result.
REQ-011 SHALL have port out_ready, input, 1: downstream takes the result this cycle.
REQ-012 SHALL have port outp, output, INP_DW+1: exact result.
REQ-013 SHALL have port out_ovf, output, 1: result not representable in INP_DW bits.

Function
REQ-014 Transfer SHALL occur on an edge where valid && ready on that side; no other condition transfers data.
REQ-015 Operands SHALL be extended to INP_DW+1 bits (zero-extended if SIGNED=0, sign-extended if 1); subtract SHALL use inverted inp2 with carry-in 1.
REQ-016 Datapath SHALL be split into NUM_REG segments of SEG_W = ceil((INP_DW+1)/NUM_REG) bits, last segment taking the remainder; stage k SHALL add segment k using the registered carry from stage k-1.
REQ-017 Upper operand segments not yet summed SHALL travel registered alongside each stage's partial result.
REQ-018 outp SHALL equal the exact result mod 2^(INP_DW+1): unsigned-add read as unsigned, otherwise as signed.
REQ-019 out_ovf SHALL be outp[INP_DW] when SIGNED=0 (carry for add, negative for sub), and outp[INP_DW]^outp[INP_DW-1] when SIGNED=1.
REQ-020 Latency SHALL be exactly NUM_REG cycles from input transfer to out_valid when out_ready stays 1.
REQ-021 Each stage SHALL hold a valid bit; stage k SHALL load when its own valid is 0 or stage k+1 loads (output stage: out_ready); in_ready SHALL equal stage-0 load enable.
REQ-022 Throughput SHALL be one result per cycle with out_ready continuously 1; bubbles SHALL collapse when downstream stalls.
REQ-023 While out_valid=1 and out_ready=0, outp and out_ovf SHALL remain stable.
REQ-024 With all NUM_REG stages full and out_ready=0, in_ready SHALL be 0; simultaneous out_ready=1 and in_valid=1 on a full pipe SHALL accept the new pair in the same cycle.
REQ-025 Results SHALL emerge in acceptance order; none dropped or duplicated.
REQ-026 Results SHALL not depend on inputs after transfer; in_sub SHALL be captured per pair.

Reset
REQ-027 rst_n low SHALL immediately clear all stage valid bits, outp to 0, out_ovf to 0, out_valid to 0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts; in-flight pairs at reset SHALL be discarded, never emitted.

Structure
REQ-029 Package pipelined_adder_pkg SHALL hold the seg_width function and stage-record struct (valid, sub, carry, partial sum, pending operand bits).
REQ-030 One sub-module, addsub_seg_stage, SHALL implement a single segment add plus its valid/ready register; top generates NUM_REG instances.

Verification
REQ-031 INP_DW=8, NUM_REG=4, SIGNED=0: 200+55 add -> outp=255, out_ovf=0 after exactly 4 cycles; 200+100 -> outp=300, out_ovf=1.
REQ-032 Same config: 5-10 sub -> outp=9'h1FB, out_ovf=1; 10-5 -> outp=5, out_ovf=0.
REQ-033 SIGNED=1: 127+1 -> outp=128 (9'h080), out_ovf=1; -128-1 -> outp=9'h17F, out_ovf=1; -3+-4 -> outp=9'h1F9, out_ovf=0.
REQ-034 Stream 16 pairs back-to-back with out_ready=0 for cycles 3..8 -> in_ready falls after 4 accepted, all 16 results in order, outp stable during stall.
REQ-035 Assert rst_n low with 3 pairs in flight -> out_valid=0 immediately, no stale result after release, next pair 1+1 gives outp=2.
REQ-036 Sweep NUM_REG=1,5,9 with INP_DW=8 on random add/sub traffic -> results match reference model, latency equals NUM_REG.
